alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
Upstream issue and result stage for the 16-bit combinational ALU (ports A, B, Sel, Y, cout, zero).
- Accepts ALU commands over a valid/ready interface and buffers them in a small FIFO.
- Drives one command per cycle into the ALU.
- Registers Y/cout/zero into a result register with its own valid/ready interface, giving the combinational ALU a clean pipelined boundary.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU.
- DEPTH, 4, command FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- cmd_sel  in  4  ALU opcode (0000 add .. 1111 clear).
- cmd_fwd_a  in  1  replace A with the last result (used only with ALU_FWD_EN).
- alu_a  out  WIDTH  to ALU A.
- alu_b  out  WIDTH  to ALU B.
- alu_sel  out  4  to ALU Sel.
- alu_y  in  WIDTH  from ALU Y.
- alu_cout  in  1  from ALU cout.
- alu_zero  in  1  from ALU zero.
- res_valid  out  1  result register holds a result.
- res_ready  in  1  consumer takes the result.
- res_y  out  WIDTH  registered Y.
- res_cout  out  1  registered cout.
- res_zero  out  1  registered zero.
- res_sel  out  4  opcode that produced the result.
- fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset (async, rst_n=0): FIFO pointers and count 0; res_valid 0; res_y 0; res_cout 0; res_zero 0; res_sel 0; last_y 0. Pending commands are discarded, including when reset is asserted mid-stream. Outputs settle to reset values without a clock edge.
- cmd_ready = (fifo_count < DEPTH). A full FIFO deasserts cmd_ready even if a pop occurs in the same cycle.
- Push: when cmd_valid & cmd_ready, {a, b, sel, fwd_a} is written at the tail.
- ALU drive (combinational from the FIFO head):
  - FIFO non-empty: alu_a = head.a (or last_y when forwarding applies), alu_b = head.b, alu_sel = head.sel.
  - FIFO empty: alu_a, alu_b and alu_sel are all 0.
- Result register is a 2-state FSM:
  - R_EMPTY (res_valid=0).
  - R_FULL (res_valid=1).
- pop = fifo non-empty & (R_EMPTY | res_ready).
- On pop: capture alu_y, alu_cout, alu_zero and head.sel into res_*; last_y <= alu_y; state goes to R_FULL.
- R_FULL with res_ready & no pop -> R_EMPTY. res_* are held (not cleared).
- R_FULL with res_ready & pop -> stays R_FULL with new data, giving back-to-back throughput of 1 result/cycle.
- R_FULL & !res_ready: res_* stable, no pop, FIFO fills.
- Simultaneous push and pop: fifo_count is unchanged. Pointers wrap modulo DEPTH.
- Latency: command handshaken in cycle c -> res_valid high in cycle c+2 (unloaded).
- Ordering: results are strictly in command order. No commands are dropped or duplicated.
- Capacity: total buffering is DEPTH+1 commands (FIFO plus result register).

Optional Feature:
- ALU_FWD_EN defined:
  - A head entry with fwd_a=1 drives alu_a = last_y, the Y of the most recently popped command.
  - This is correct for back-to-back pops because last_y updates on every pop edge.
- ALU_FWD_EN undefined:
  - cmd_fwd_a is ignored, not stored in the FIFO, and alu_a = head.a always.
  - The last_y register is not built.

Decomposition:
- Shared package alu_pkg holds:
  - width constant ALU_W=16.
  - 4-bit opcode localparams (OP_ADD..OP_CLR).
  - command field widths.
- Sub-module alu_cmd_fifo: parameterised synchronous FIFO with push/pop/count, async active-low reset.
- alu_issue_stage instantiates alu_cmd_fifo and contains the issue logic and result FSM.

Test Plan:
- Single op: A=0005, B=0003, Sel=0000, res_ready=1 -> res_valid 2 cycles later, res_y=0008, cout=0, zero=0, res_sel=0000.
- Stream: 4 back-to-back commands (add 5+3, sub 10-4, inc FFFF, and F0F0&AAAA) -> 4 consecutive res_valid cycles: 0008; 0006; 0000 with cout=1, zero=1; then A0A0.
- Backpressure: res_ready=0, cmd_valid held -> exactly 5 commands accepted, cmd_ready=0, fifo_count=4. Then res_ready=1 -> 5 results drained in order with no loss.
- Empty FIFO: no commands -> alu_a=0, alu_b=0, alu_sel=0000, res_valid stays 0, fifo_count=0.
- Reset mid-stream: 3 commands queued, res_valid=1, rst_n pulsed low -> immediately res_valid=0, fifo_count=0, cmd_ready=1. No stale result appears after reset.
- Forwarding (ALU_FWD_EN): cmd1 A=0005 B=0003 add; cmd2 fwd_a=1 B=0004 Sel=0001 issued back-to-back -> results 0008 then 0004. Without the macro, cmd2 uses cmd_a instead.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: operand width, opcodes and
// command field widths.
// Optional feature macro: ALU_FWD_EN (forward last result into operand A).
package alu_pkg;

  localparam int unsigned ALU_W = 16;
  localparam int unsigned SEL_W = 4;

`ifdef ALU_FWD_EN
  localparam int unsigned FWD_W = 1;
`else
  localparam int unsigned FWD_W = 0;
`endif

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_INC  = 4'h2;
  localparam logic [3:0] OP_DEC  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_ROL  = 4'hA;
  localparam logic [3:0] OP_ROR  = 4'hB;
  localparam logic [3:0] OP_PASA = 4'hC;
  localparam logic [3:0] OP_PASB = 4'hD;
  localparam logic [3:0] OP_NEG  = 4'hE;
  localparam logic [3:0] OP_CLR  = 4'hF;

  // Packed command width: two operands, opcode and (optionally) the forward flag.
  function automatic int unsigned cmd_w(input int unsigned w);
    return 2 * w + SEL_W + FWD_W;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with occupancy count. DEPTH must be a power of two
// so the pointers wrap naturally.
module alu_cmd_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage array; contents are don't-care while the entry is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue and result stage around a combinational 16-bit ALU: buffers commands,
// drives the FIFO head into the ALU and registers its outputs.
// Optional feature macro: ALU_FWD_EN (head entries may take A from last result).
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [WIDTH-1:0]       cmd_a,
  input  logic [WIDTH-1:0]       cmd_b,
  input  logic [SEL_W-1:0]       cmd_sel,
  input  logic                   cmd_fwd_a,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [SEL_W-1:0]       alu_sel,
  input  logic [WIDTH-1:0]       alu_y,
  input  logic                   alu_cout,
  input  logic                   alu_zero,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_y,
  output logic                   res_cout,
  output logic                   res_zero,
  output logic [SEL_W-1:0]       res_sel,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned CMD_W = cmd_w(WIDTH);

  localparam logic R_EMPTY = 1'b0;
  localparam logic R_FULL  = 1'b1;

  logic [CMD_W-1:0] fifo_wdata, fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  logic [WIDTH-1:0] head_a, head_b;
  logic [SEL_W-1:0] head_sel;

  logic             state_q, state_d;
  logic [WIDTH-1:0] res_y_q;
  logic             res_cout_q, res_zero_q;
  logic [SEL_W-1:0] res_sel_q;

`ifdef ALU_FWD_EN
  logic             head_fwd;
  logic [WIDTH-1:0] last_y_q;
  assign fifo_wdata = {cmd_fwd_a, cmd_a, cmd_b, cmd_sel};
  assign {head_fwd, head_a, head_b, head_sel} = fifo_rdata;
`else
  logic unused_fwd_a;
  assign unused_fwd_a = cmd_fwd_a;
  assign fifo_wdata = {cmd_a, cmd_b, cmd_sel};
  assign {head_a, head_b, head_sel} = fifo_rdata;
`endif

  assign cmd_ready = ~fifo_full;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = ~fifo_empty & ((state_q == R_EMPTY) | res_ready);

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ALU operands come straight from the FIFO head; zero when nothing is queued.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    if (!fifo_empty) begin
      alu_a   = head_a;
`ifdef ALU_FWD_EN
      if (head_fwd) alu_a = last_y_q;
`endif
      alu_b   = head_b;
      alu_sel = head_sel;
    end
  end

  // Result register occupancy: a pop always refills it, otherwise a take empties it.
  always_comb begin
    state_d = state_q;
    if (pop) begin
      state_d = R_FULL;
    end else if (state_q == R_FULL && res_ready) begin
      state_d = R_EMPTY;
    end
  end

  // Result capture; data is held (not cleared) when the consumer drains it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= R_EMPTY;
      res_y_q    <= '0;
      res_cout_q <= 1'b0;
      res_zero_q <= 1'b0;
      res_sel_q  <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        res_y_q    <= alu_y;
        res_cout_q <= alu_cout;
        res_zero_q <= alu_zero;
        res_sel_q  <= head_sel;
      end
    end
  end

`ifdef ALU_FWD_EN
  // Y of the most recently issued command, for forwarding into operand A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_y_q <= '0;
    end else if (pop) begin
      last_y_q <= alu_y;
    end
  end
`endif

  assign res_valid = state_q;
  assign res_y     = res_y_q;
  assign res_cout  = res_cout_q;
  assign res_zero  = res_zero_q;
  assign res_sel   = res_sel_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a stand-in ALU, a queue-based model of the stage
// compared every cycle, plus literal expectations for the directed scenarios.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [15:0] cmd_a = '0, cmd_b = '0;
  logic [3:0]  cmd_sel = '0;
  logic        cmd_fwd_a = 1'b0;
  logic [15:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_sel;
  logic        alu_cout, alu_zero;
  logic        res_valid, res_ready = 1'b1;
  logic [15:0] res_y;
  logic        res_cout, res_zero;
  logic [3:0]  res_sel;
  logic [2:0]  fifo_count;
  logic [16:0] alu_r;

  alu_issue_stage #(.WIDTH(16), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_fwd_a(cmd_fwd_a),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
    .alu_cout(alu_cout), .alu_zero(alu_zero), .res_valid(res_valid),
    .res_ready(res_ready), .res_y(res_y), .res_cout(res_cout), .res_zero(res_zero),
    .res_sel(res_sel), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] sel);
    logic [16:0] r;
    case (sel)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_INC:  r = {1'b0, a} + 17'd1;
      OP_DEC:  r = {1'b0, a} - 17'd1;
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_NOT:  r = {1'b0, ~a};
      OP_CLR:  r = '0;
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  // Stand-in for the combinational ALU.
  assign alu_r    = alu_fn(alu_a, alu_b, alu_sel);
  assign alu_y    = alu_r[15:0];
  assign alu_cout = alu_r[16];
  assign alu_zero = (alu_r[15:0] == 16'h0);

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  sel;
    logic        fwd;
  } cmd_t;

  cmd_t        m_fifo[$];
  logic        m_full;
  logic [15:0] m_y, m_last;
  logic        m_cout, m_zero;
  logic [3:0]  m_sel;

  int n_tests = 0, n_fail = 0, cyc = 0, acc_cnt = 0;
  logic [15:0] seen_y[$];
  logic        seen_c[$], seen_z[$];
  int          seen_t[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_full = 1'b0;
    m_y    = '0;
    m_cout = 1'b0;
    m_zero = 1'b0;
    m_sel  = '0;
    m_last = '0;
  endtask

  task automatic compare();
    cmd_t        h;
    logic [15:0] ea;
    chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, m_fifo.size() < D});
    chk("fifo_count", {29'b0, fifo_count}, 32'(m_fifo.size()));
    chk("res_valid", {31'b0, res_valid}, {31'b0, m_full});
    chk("res_y", {16'b0, res_y}, {16'b0, m_y});
    chk("res_cout", {31'b0, res_cout}, {31'b0, m_cout});
    chk("res_zero", {31'b0, res_zero}, {31'b0, m_zero});
    chk("res_sel", {28'b0, res_sel}, {28'b0, m_sel});
    if (m_fifo.size() == 0) begin
      chk("alu_idle", {alu_a, alu_b[11:0], alu_sel}, 32'h0);
    end else begin
      h  = m_fifo[0];
      ea = h.a;
`ifdef ALU_FWD_EN
      if (h.fwd) ea = m_last;
`endif
      chk("alu_a", {16'b0, alu_a}, {16'b0, ea});
      chk("alu_b", {16'b0, alu_b}, {16'b0, h.b});
      chk("alu_sel", {28'b0, alu_sel}, {28'b0, h.sel});
    end
  endtask

  task automatic model_step();
    logic        do_push, do_pop;
    cmd_t        h, c;
    logic [15:0] a;
    logic [16:0] r;
    do_push = cmd_valid && (m_fifo.size() < D);
    do_pop  = (m_fifo.size() > 0) && (!m_full || res_ready);
    if (do_pop) begin
      h = m_fifo.pop_front();
      a = h.a;
`ifdef ALU_FWD_EN
      if (h.fwd) a = m_last;
`endif
      r      = alu_fn(a, h.b, h.sel);
      m_y    = r[15:0];
      m_cout = r[16];
      m_zero = (r[15:0] == 16'h0);
      m_sel  = h.sel;
      m_last = r[15:0];
      m_full = 1'b1;
    end else if (m_full && res_ready) begin
      m_full = 1'b0;
    end
    if (do_push) begin
      c.a   = cmd_a;
      c.b   = cmd_b;
      c.sel = cmd_sel;
`ifdef ALU_FWD_EN
      c.fwd = cmd_fwd_a;
`else
      c.fwd = 1'b0;
`endif
      m_fifo.push_back(c);
    end
  endtask

  // One clock: check on the falling edge, advance the model, return after the rising edge.
  task automatic cycle();
    @(negedge clk);
    compare();
    if (cmd_valid && cmd_ready) acc_cnt++;
    if (res_valid && res_ready) begin
      seen_y.push_back(res_y);
      seen_c.push_back(res_cout);
      seen_z.push_back(res_zero);
      seen_t.push_back(cyc);
    end
    model_step();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] sel,
                         input logic fwd);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_sel   = sel;
    cmd_fwd_a = fwd;
  endtask

  task automatic clear_seen();
    seen_y.delete();
    seen_c.delete();
    seen_z.delete();
    seen_t.delete();
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < 30 && seen_y.size() < n; k++) cycle();
    chk("drain_count", 32'(seen_y.size()), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #3;
    chk("rst_res_valid", {31'b0, res_valid}, 32'h0);
    chk("rst_fifo_count", {29'b0, fifo_count}, 32'h0);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    chk("rst_res_y", {16'b0, res_y}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single add, unloaded latency.
    res_ready = 1'b1;
    set_cmd(16'h0005, 16'h0003, OP_ADD, 1'b0);
    cycle();
    cmd_valid = 1'b0;
    chk("single_c1_valid", {31'b0, res_valid}, 32'h0);
    cycle();
    chk("single_c2_valid", {31'b0, res_valid}, 32'h1);
    chk("single_y", {16'b0, res_y}, 32'h0008);
    chk("single_flags", {30'b0, res_cout, res_zero}, 32'h0);
    chk("single_sel", {28'b0, res_sel}, 32'h0);
    cycle();

    // Back-to-back stream.
    clear_seen();
    set_cmd(16'h0005, 16'h0003, OP_ADD, 1'b0); cycle();
    set_cmd(16'h000A, 16'h0004, OP_SUB, 1'b0); cycle();
    set_cmd(16'hFFFF, 16'h0000, OP_INC, 1'b0); cycle();
    set_cmd(16'hF0F0, 16'hAAAA, OP_AND, 1'b0); cycle();
    cmd_valid = 1'b0;
    drain(4);
    if (seen_y.size() >= 4) begin
      chk("stream_y0", {16'b0, seen_y[0]}, 32'h0008);
      chk("stream_y1", {16'b0, seen_y[1]}, 32'h0006);
      chk("stream_y2", {16'b0, seen_y[2]}, 32'h0000);
      chk("stream_f2", {30'b0, seen_c[2], seen_z[2]}, 32'h3);
      chk("stream_y3", {16'b0, seen_y[3]}, 32'hA0A0);
      chk("stream_b2b", 32'(seen_t[3] - seen_t[0]), 32'd3);
    end

    // Backpressure: FIFO plus result register hold DEPTH+1 commands.
    res_ready = 1'b0;
    acc_cnt   = 0;
    for (int i = 0; i < 8; i++) begin
      set_cmd(16'h0100 + 16'(i), 16'(i), OP_ADD, 1'b0);
      cycle();
    end
    chk("bp_accepted", 32'(acc_cnt), 32'd5);
    chk("bp_cmd_ready", {31'b0, cmd_ready}, 32'h0);
    chk("bp_fifo_count", {29'b0, fifo_count}, 32'd4);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    clear_seen();
    drain(5);
    for (int i = 0; i < 5; i++) begin
      if (i < seen_y.size()) chk("bp_order", {16'b0, seen_y[i]}, 32'h0100 + 32'(2 * i));
    end

    // Idle: ALU inputs forced to zero.
    repeat (3) cycle();
    chk("idle_alu", {alu_a, alu_b[11:0], alu_sel}, 32'h0);
    chk("idle_valid", {31'b0, res_valid}, 32'h0);
    chk("idle_count", {29'b0, fifo_count}, 32'h0);

    // Reset mid-stream.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_cmd(16'h0011 * 16'(i + 1), 16'h0001, OP_ADD, 1'b0);
      cycle();
    end
    cmd_valid = 1'b0;
    chk("pre_rst_valid", {31'b0, res_valid}, 32'h1);
    chk("pre_rst_count", {29'b0, fifo_count}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, res_valid}, 32'h0);
    chk("mid_rst_count", {29'b0, fifo_count}, 32'h0);
    chk("mid_rst_ready", {31'b0, cmd_ready}, 32'h1);
    chk("mid_rst_y", {16'b0, res_y}, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    clear_seen();
    repeat (5) cycle();
    chk("post_rst_stale", 32'(seen_y.size()), 32'h0);

    // Forwarding of the previous result into A.
    clear_seen();
    set_cmd(16'h0005, 16'h0003, OP_ADD, 1'b0); cycle();
    set_cmd(16'h0009, 16'h0004, OP_SUB, 1'b1); cycle();
    cmd_valid = 1'b0;
    cmd_fwd_a = 1'b0;
    drain(2);
    if (seen_y.size() >= 2) begin
      chk("fwd_y0", {16'b0, seen_y[0]}, 32'h0008);
`ifdef ALU_FWD_EN
      chk("fwd_y1", {16'b0, seen_y[1]}, 32'h0004);
`else
      chk("fwd_y1", {16'b0, seen_y[1]}, 32'h0005);
`endif
    end
    repeat (2) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
